serial_paralelo_rx_com: RTL and testbench
=========================================

# serial_paralelo_rx_com

Receive-side 1-to-8 deserializer with COM-symbol (K28.5, 0xBC) byte alignment, running on the serial bit clock. It hunts for the COM pattern at any bit offset, locks the byte boundary, and declares the link active after four consecutive aligned COMs. It then presents bytes with a valid flag to the 8-to-32 demux stage downstream. COM bytes received while active are idle fill: they are forwarded with valid low.

## Interface
- COM, 8'hBC: alignment/idle symbol.
- COM_LOCK, 4: consecutive aligned COMs required to go active (range 2..7).
- clk_32f  input  1  serial bit clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk_32f.
- data_in  input  1  serial bit stream, MSB of each byte first.
- data_out  output  8  deserialized byte, held between byte boundaries.
- valid_out  output  1  data_out is a data byte (not COM), active only.
- byte_tick  output  1  one-cycle pulse when data_out/valid_out update.
- active  output  1  link aligned and locked; sticky until reset.

## Operation
- Shift register sr[7:0] shifts left every cycle: sr <= {sr[6:0], data_in}. Window w = {sr[6:0], data_in} (current byte candidate, combinational).
- 3-bit bit counter bit_cnt increments every cycle and wraps 7 -> 0. A byte boundary is a cycle with bit_cnt == 7.
- States: HUNT, ALIGN, ACTIVE.
- HUNT: compare w to COM every cycle regardless of bit_cnt. On a match, force bit_cnt <= 0, com_cnt <= 1, and go to ALIGN. This sets the next boundary exactly 8 bits later.
- ALIGN: at each boundary:
  - w == COM: com_cnt++. If com_cnt+1 == COM_LOCK, go to ACTIVE and set active <= 1.
  - w != COM: com_cnt <= 0, go to HUNT. bit_cnt keeps counting, with no re-lock until the next COM match.
- ACTIVE: at each boundary, data_out <= w, valid_out <= (w != COM), byte_tick <= 1. byte_tick is 0 on all other cycles. Non-COM bytes never cause loss of lock; only reset leaves ACTIVE.
- The COM that completes the lock does not produce a byte_tick. The first byte_tick is at the following boundary.
- Reset values (next edge with reset=1): state HUNT, sr 8'h00, bit_cnt 0, com_cnt 0, data_out 8'h00, valid_out 0, byte_tick 0, active 0.
- Reset mid-operation: all of the above take effect at that edge, whatever the state. Re-acquisition requires a full HUNT plus COM_LOCK COMs.
- An all-zero or all-one stream never matches COM, so the block stays in HUNT indefinitely with outputs at reset values.

## Timing
- Registered outputs only; no combinational path from data_in to any output.
- Latency: the last (LSB) bit of a byte is sampled at edge N. data_out, valid_out and byte_tick reflect that byte after edge N. They hold for 8 cycles; byte_tick is high for the one cycle after edge N.
- Lock timing: with the first COM's LSB sampled at edge L, active rises after edge L + 8·(COM_LOCK−1). The first byte_tick follows 8 edges later.
- Byte rate is 1/8 of clk_32f. The downstream demux clock must be phase-related by design; this block provides byte_tick for checking.

## Test plan
- Reset: hold reset=1 for 3 cycles with random data_in. Required: data_out=00, valid_out=0, byte_tick=0, active=0 throughout and after release until a lock.
- Aligned lock plus data: after reset, send BC×4, then EE, FF, FD, CC, AA, 12, BB MSB-first. Required:
  - active rises 24 cycles after the first COM's LSB edge.
  - Seven byte_ticks, 8 cycles apart, with data_out EE, FF, FD, CC, AA, 12, BB and valid_out=1 on each.
- Misaligned start: prefix 3 junk bits (101) before BC×4 plus data. Required: identical outputs, shifted by 3 cycles.
- Failed lock: send BC×3, then 55, then BC×4, then 0x3C. Required:
  - No lock after the 55; return to HUNT.
  - active rises on the fourth COM of the second run.
  - data_out=3C with valid_out=1.
- Idle in active: after lock, send 10, BC, 20. Required: ticks with (10,1), (BC,0), (20,1); active stays 1.
- Reset mid-stream: assert reset=1 for one cycle in the middle of a data byte while active. Required:
  - All outputs return to reset values on that edge.
  - The next byte_tick occurs only after a fresh BC×4 lock.

Source files
------------

// File: rtl/serial_paralelo_rx_com_if.sv
// Serial receive bus: bit stream in, aligned bytes with valid/tick/lock status out.
// master drives the serial line; slave is the deserializer.
interface serial_paralelo_rx_com_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_tick;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_tick,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_tick,
        output active
    );
endinterface

// File: rtl/serial_paralelo_rx_com.sv
// 1-to-8 deserializer that hunts for COM at any bit offset, locks the byte boundary, then emits bytes.
// Outputs update one cycle after a byte's LSB edge and hold for 8 cycles; no backpressure (fixed bit rate).
module serial_paralelo_rx_com #(
    parameter logic [7:0] COM      = 8'hBC,
    parameter int         COM_LOCK = 4
) (
    input  logic                          clk_32f,
    input  logic                          reset,
    serial_paralelo_rx_com_if.slave       bus
);
    typedef enum logic [1:0] {HUNT, ALIGN, ACTIVE} state_t;

    localparam logic [3:0] LOCK_N = 4'(COM_LOCK);

    state_t     state_q;
    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic [2:0] com_cnt_q;
    logic [7:0] data_out_q;
    logic       valid_q;
    logic       tick_q;
    logic       active_q;

    logic [7:0] win_d;
    logic       boundary_d;
    logic       com_hit_d;
    logic [3:0] com_next_d;

    // The byte candidate includes the bit arriving this cycle.
    assign win_d      = {sr_q[6:0], bus.data_in};
    assign boundary_d = (bit_cnt_q == 3'd7);
    assign com_hit_d  = (win_d == COM);
    assign com_next_d = {1'b0, com_cnt_q} + 4'd1;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q    <= HUNT;
            sr_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            com_cnt_q  <= 3'd0;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            tick_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            sr_q      <= win_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            tick_q    <= 1'b0;
            case (state_q)
                HUNT: begin
                    // Restart the bit counter so the next boundary lands 8 bits after this COM.
                    if (com_hit_d) begin
                        bit_cnt_q <= 3'd0;
                        com_cnt_q <= 3'd1;
                        state_q   <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (boundary_d) begin
                        if (com_hit_d) begin
                            com_cnt_q <= com_next_d[2:0];
                            if (com_next_d == LOCK_N) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            com_cnt_q <= 3'd0;
                            state_q   <= HUNT;
                        end
                    end
                end
                ACTIVE: begin
                    if (boundary_d) begin
                        data_out_q <= win_d;
                        valid_q    <= !com_hit_d;
                        tick_q     <= 1'b1;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_q;
    assign bus.byte_tick = tick_q;
    assign bus.active    = active_q;
endmodule

// File: tb/tb_serial_paralelo_rx_com.sv
// Randomized scoreboard bench: a bit-stream search model predicts lock point and byte ticks.
module tb_serial_paralelo_rx_com;
    localparam logic [7:0] COM      = 8'hBC;
    localparam int         COM_LOCK = 4;

    typedef struct {
        int         edge_no;
        logic [7:0] d;
        logic       v;
    } exp_t;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    serial_paralelo_rx_com_if bus ();

    serial_paralelo_rx_com #(.COM(COM), .COM_LOCK(COM_LOCK)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_32f = ~clk_32f;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   tick_seen = 0;
    int   last_act_edge = -1;
    logic prev_act = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_v = 1'b0;
    logic model_locked;

    exp_t exp_q[$];
    int   exp_act_q[$];
    logic stim_q[$];

    always @(posedge clk_32f) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Monitor: every negedge, pop expectations on ticks / active rise and check held outputs.
    always @(negedge clk_32f) begin
        exp_t e;
        if (bus.byte_tick) begin
            tick_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", {24'd0, bus.data_out}, 32'hFFFF_FFFF);
                hold_d = bus.data_out;
                hold_v = bus.valid_out;
            end else begin
                e = exp_q.pop_front();
                chk("tick_edge", edge_cnt, e.edge_no);
                chk("tick_data", {24'd0, bus.data_out}, {24'd0, e.d});
                chk("tick_valid", {31'd0, bus.valid_out}, {31'd0, e.v});
                hold_d = e.d;
                hold_v = e.v;
            end
        end else if (bus.active) begin
            chk("held_out", {23'd0, bus.valid_out, bus.data_out}, {23'd0, hold_v, hold_d});
        end
        if (!bus.active) begin
            chk("unlocked_out", {22'd0, bus.byte_tick, bus.valid_out, bus.data_out}, 32'd0);
            hold_d = 8'h00;
            hold_v = 1'b0;
        end
        if (bus.active && !prev_act) begin
            last_act_edge = edge_cnt;
            if (exp_act_q.size() == 0) chk("unexpected_active", edge_cnt, 32'hFFFF_FFFF);
            else chk("active_edge", edge_cnt, exp_act_q.pop_front());
        end
        prev_act = bus.active;
    end

    function automatic logic [7:0] win_at(input int i);
        logic [7:0] w = 8'h00;
        for (int j = i - 7; j <= i; j++) w = {w[6:0], (j >= 0) ? stim_q[j] : 1'b0};
        return w;
    endfunction

    // Reference: search for a COM, then demand COM_LOCK-1 more COMs every 8 bits;
    // on a miss, resume the search one bit after the failing boundary.
    task automatic model_stream(input int base);
        int n = stim_q.size();
        int i = 0;
        int p = 0;
        int cnt;
        int lockpos = -1;
        bit fail;
        exp_t e;
        while (i < n && lockpos < 0) begin
            if (win_at(i) == COM) begin
                cnt = 1; p = i; fail = 0;
                while (cnt < COM_LOCK && !fail && p + 8 < n) begin
                    p += 8;
                    if (win_at(p) == COM) cnt++;
                    else fail = 1;
                end
                if (cnt == COM_LOCK) lockpos = p;
                else if (fail) i = p + 1;
                else i = n;
            end else begin
                i++;
            end
        end
        model_locked = (lockpos >= 0);
        if (model_locked) begin
            exp_act_q.push_back(base + lockpos);
            for (int q = lockpos + 8; q < n; q += 8) begin
                e.edge_no = base + q;
                e.d = win_at(q);
                e.v = (e.d != COM);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) stim_q.push_back(b[k]);
    endtask

    task automatic add_bits(input int n);
        for (int k = 0; k < n; k++) stim_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic add_lock();
        repeat (COM_LOCK) add_byte(COM);
    endtask

    // Drives are applied just after a negedge; returns at negedge+1.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            bus.data_in = 1'($urandom_range(0, 1));
            @(negedge clk_32f); #1;
            chk("reset_out", {21'd0, bus.active, bus.byte_tick, bus.valid_out, bus.data_out}, 32'd0);
        end
        reset = 1'b0;
    endtask

    task automatic run_stream(input string name, input int exp_ticks, input int exp_active, output int base);
        int t0 = tick_seen;
        base = edge_cnt + 1;
        model_stream(base);
        for (int i = 0; i < stim_q.size(); i++) begin
            bus.data_in = stim_q[i];
            @(negedge clk_32f); #1;
        end
        chk({name, "_ticks_left"}, exp_q.size(), 0);
        chk({name, "_active_left"}, exp_act_q.size(), 0);
        chk({name, "_active_model"}, {31'd0, bus.active}, {31'd0, model_locked});
        if (exp_ticks >= 0) chk({name, "_tick_count"}, tick_seen - t0, exp_ticks);
        if (exp_active >= 0) chk({name, "_active"}, {31'd0, bus.active}, exp_active);
        exp_q.delete();
        exp_act_q.delete();
        stim_q.delete();
    endtask

    initial begin
        int base;
        logic [7:0] data7 [7];
        data7 = '{8'hEE, 8'hFF, 8'hFD, 8'hCC, 8'hAA, 8'h12, 8'hBB};
        bus.data_in = 1'b0;
        #1;

        do_reset(3);
        add_bits(40);
        if (stim_q.size() > 0) stim_q.delete();
        add_byte(8'h00); add_byte(8'h00);
        run_stream("post_reset_idle", 0, 0, base);

        do_reset(2);
        add_lock();
        foreach (data7[k]) add_byte(data7[k]);
        run_stream("aligned", 7, 1, base);
        chk("aligned_lock_time", last_act_edge - base, 31);

        do_reset(2);
        stim_q.push_back(1'b1); stim_q.push_back(1'b0); stim_q.push_back(1'b1);
        add_lock();
        foreach (data7[k]) add_byte(data7[k]);
        run_stream("misaligned", 7, 1, base);
        chk("misaligned_lock_time", last_act_edge - base, 34);

        do_reset(2);
        repeat (3) add_byte(COM);
        add_byte(8'h55);
        add_lock();
        add_byte(8'h3C);
        run_stream("failed_lock", 1, 1, base);
        chk("failed_lock_time", last_act_edge - base, 63);
        chk("failed_lock_data", {23'd0, bus.valid_out, bus.data_out}, {23'd0, 1'b1, 8'h3C});

        do_reset(2);
        add_lock();
        add_byte(8'h10); add_byte(COM); add_byte(8'h20);
        run_stream("idle_fill", 3, 1, base);

        do_reset(2);
        repeat (8) add_byte(8'h00);
        run_stream("all_zero", 0, 0, base);
        do_reset(1);
        repeat (8) add_byte(8'hFF);
        run_stream("all_one", 0, 0, base);

        do_reset(2);
        add_lock();
        add_byte(8'h11); add_byte(8'h22);
        stim_q.push_back(1'b0); stim_q.push_back(1'b0); stim_q.push_back(1'b1); stim_q.push_back(1'b1);
        run_stream("pre_midreset", 2, 1, base);
        do_reset(1);
        add_byte(8'h44);
        add_byte(8'h00);
        run_stream("post_midreset_nolock", 0, 0, base);
        add_lock();
        add_byte(8'h44);
        run_stream("relock", 1, 1, base);

        for (int r = 0; r < 6; r++) begin
            do_reset(1 + r % 2);
            add_bits($urandom_range(0, 12));
            add_lock();
            repeat (6) add_byte(8'($urandom_range(0, 255)));
            if (r % 3 == 0) add_byte(COM);
            run_stream("random_lock", -1, 1, base);
        end

        do_reset(1);
        add_bits(300);
        run_stream("random_bits", -1, -1, base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
